operand_fwd_unit: RTL
=====================

// Module: operand_fwd_unit
// PURPOSE
//  Parametrised successor to the EX operand-A forwarding mux for the RV32 5-stage pipeline.
//  Sits at the ID/EX boundary and builds both EX operands (A and B).
//  Tracks in-flight destinations internally (EX/MEM/WB slots) and picks forward sources by priority.
//  Detects load-use hazards and stalls ID; registers the selected operands into EX.
// PARAMETERS
//  DATAWIDTH  32  operand / data width
//  REGADDR    5   register-address width; register 0 is hard-wired zero, never forwarded
// PORTS
//  clk          in   1          clock, rising edge
//  rst_n        in   1          asynchronous, active-low reset
//  freeze       in   1          global pipeline hold (memory busy)
//  id_valid     in   1          ID holds a real instruction
//  id_rs1       in   REGADDR    source register 1
//  id_rs2       in   REGADDR    source register 2
//  id_rdata1    in   DATAWIDTH  register-file read data 1
//  id_rdata2    in   DATAWIDTH  register-file read data 2
//  id_pc        in   DATAWIDTH  PC of the ID instruction
//  id_imm       in   DATAWIDTH  immediate
//  id_asel      in   1          1: opA = PC, 0: opA = rs1
//  id_bsel      in   1          1: opB = imm, 0: opB = rs2
//  id_rd        in   REGADDR    destination register
//  id_we        in   1          instruction writes rd
//  id_is_load   in   1          instruction is a load
//  ex_alu_data  in   DATAWIDTH  ALU result of the EX-slot instruction (combinational)
//  mem_data     in   DATAWIDTH  result of the MEM-slot instruction (ALU or load data)
//  wb_data      in   DATAWIDTH  result of the WB-slot instruction
//  stall_id     out  1          hold PC/IF/ID this cycle (combinational)
//  ex_valid     out  1          registered: EX operands are valid
//  ex_opa       out  DATAWIDTH  registered EX operand A
//  ex_opb       out  DATAWIDTH  registered EX operand B
//  fwd_sel_a    out  2          registered select A: 00 RF/PC, 01 WB, 10 MEM, 11 EX
//  fwd_sel_b    out  2          registered select B, same encoding (00 also covers imm)
//  stat_stall   out  32         load-use stall cycle count (see CONFIGURATION)
//  stat_fwd     out  32         forward event count (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async, rst_n=0):
//    - all EX/MEM/WB slots invalid; FSM = RUN
//    - ex_valid, ex_opa, ex_opb, fwd_sel_a, fwd_sel_b = 0; stat counters = 0
//  - Slot tracking: each of EX/MEM/WB holds {valid, rd, we, is_load}.
//    - Per clock, unless freeze: WB<=MEM, MEM<=EX.
//    - EX <= ID fields when id_valid & !stall_id; otherwise EX <= bubble (valid=0).
//  - Slot match: slot.valid & slot.we & slot.rd!=0 & slot.rd==rs.
//  - Use flags: rs1 is used only when !id_asel; rs2 is used only when !id_bsel.
//  - Forward priority per used operand: EX (ex_alu_data) > MEM (mem_data) > WB (wb_data) > id_rdata.
//  - Unused operand: opA = id_pc, opB = id_imm, select code 00.
//  - Load-use hazard: EX slot is_load and matches a used rs -> stall_id=1, FSM RUN->LDSTALL.
//    - LDSTALL lasts exactly 1 cycle, inserts an EX bubble, then returns to RUN.
//    - The load is then in MEM and is forwarded from mem_data.
//  - stall_id = hazard & !freeze & state==RUN; never asserted when ID is a bubble.
//  - Latency: operands and selects are registered at the ID->EX edge (1 cycle); ex_valid = EX slot valid.
//  - freeze=1: slots, FSM, ex_* outputs and counters all hold; stall_id=0. Freeze wins over hazard.
//  - freeze released mid-LDSTALL: the stall completes in the next unfrozen cycle.
//  - rs1==rs2, both matching: both operands receive the same forward source.
// CONFIGURATION
//  FWD_STATS_EN defined:
//    - stat_stall += 1 on each LDSTALL cycle.
//    - stat_fwd += 1 per issued instruction with any non-00 select.
//    - Both counters saturate at 32'hFFFF_FFFF.
//  FWD_STATS_EN undefined: no counter logic; stat_stall and stat_fwd are tied to 0.
// TESTING
//  - Reset mid-stream -> all ex_* and selects read 0, stall_id=0 within the same cycle.
//  - Back-to-back ALU dependency:
//    - Stimulus: addi x5 (ex_alu_data=7), then add x6,x5,x5.
//    - Required: ex_opa=ex_opb=7, selects 11, no stall.
//  - Load-use dependency:
//    - Stimulus: lw x3, then add x4,x3,x1.
//    - Required: stall_id=1 for 1 cycle, EX bubble, then opA=mem_data (0xDEAD), sel_a=10.
//  - Forward from WB: x8 in WB only -> ex_opa=wb_data, sel 01; rd=0 producer -> id_rdata used, sel 00.
//  - asel=1 with rs1 = in-flight load rd -> no stall, ex_opa=id_pc (0x100).
//  - Freeze held 3 cycles during a hazard -> outputs/slots hold, stall_id=0, then 1-cycle stall resumes.

Source files
------------

// File: rtl/operand_fwd_unit.sv
// EX operand builder: forwards A/B from EX/MEM/WB slots, stalls ID on load-use.
// Optional statistics counters are enabled by defining FWD_STATS_EN.
module operand_fwd_unit #(
    parameter int DATAWIDTH = 32,
    parameter int REGADDR   = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 freeze,
    input  logic                 id_valid,
    input  logic [REGADDR-1:0]   id_rs1,
    input  logic [REGADDR-1:0]   id_rs2,
    input  logic [DATAWIDTH-1:0] id_rdata1,
    input  logic [DATAWIDTH-1:0] id_rdata2,
    input  logic [DATAWIDTH-1:0] id_pc,
    input  logic [DATAWIDTH-1:0] id_imm,
    input  logic                 id_asel,
    input  logic                 id_bsel,
    input  logic [REGADDR-1:0]   id_rd,
    input  logic                 id_we,
    input  logic                 id_is_load,
    input  logic [DATAWIDTH-1:0] ex_alu_data,
    input  logic [DATAWIDTH-1:0] mem_data,
    input  logic [DATAWIDTH-1:0] wb_data,
    output logic                 stall_id,
    output logic                 ex_valid,
    output logic [DATAWIDTH-1:0] ex_opa,
    output logic [DATAWIDTH-1:0] ex_opb,
    output logic [1:0]           fwd_sel_a,
    output logic [1:0]           fwd_sel_b,
    output logic [31:0]          stat_stall,
    output logic [31:0]          stat_fwd
);

    typedef struct packed {
        logic               valid;
        logic [REGADDR-1:0] rd;
        logic               we;
    } slot_t;

    typedef enum logic {RUN, LDSTALL} state_t;

    // Only the EX slot needs is_load: a load leaving EX is forwardable.
    slot_t  ex_s, mem_s, wb_s;
    logic   ex_is_load;
    state_t state, state_nx;

    logic [DATAWIDTH-1:0] opa_d, opb_d;
    logic [1:0]           sel_a_d, sel_b_d;
    logic                 hazard, issue, in_ldstall;

    function automatic logic hit(input slot_t s, input logic [REGADDR-1:0] rs);
        return s.valid && s.we && (s.rd != '0) && (s.rd == rs);
    endfunction

    // Operand A source select, youngest producer first
    always_comb begin
        sel_a_d = 2'b00;
        opa_d   = id_rdata1;
        priority case (1'b1)
            id_asel:           begin sel_a_d = 2'b00; opa_d = id_pc;       end
            hit(ex_s, id_rs1): begin sel_a_d = 2'b11; opa_d = ex_alu_data; end
            hit(mem_s, id_rs1):begin sel_a_d = 2'b10; opa_d = mem_data;    end
            hit(wb_s, id_rs1): begin sel_a_d = 2'b01; opa_d = wb_data;     end
            default:           begin sel_a_d = 2'b00; opa_d = id_rdata1;   end
        endcase
    end

    // Operand B source select, same priority
    always_comb begin
        sel_b_d = 2'b00;
        opb_d   = id_rdata2;
        priority case (1'b1)
            id_bsel:           begin sel_b_d = 2'b00; opb_d = id_imm;      end
            hit(ex_s, id_rs2): begin sel_b_d = 2'b11; opb_d = ex_alu_data; end
            hit(mem_s, id_rs2):begin sel_b_d = 2'b10; opb_d = mem_data;    end
            hit(wb_s, id_rs2): begin sel_b_d = 2'b01; opb_d = wb_data;     end
            default:           begin sel_b_d = 2'b00; opb_d = id_rdata2;   end
        endcase
    end

    assign hazard = id_valid && ex_is_load &&
                    ((!id_asel && hit(ex_s, id_rs1)) ||
                     (!id_bsel && hit(ex_s, id_rs2)));

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_nx;
    end

    // FSM next state: one bubble cycle per load-use hazard
    always_comb begin
        state_nx = state;
        unique case (state)
            RUN:     if (stall_id) state_nx = LDSTALL;
            LDSTALL: if (!freeze)  state_nx = RUN;
            default: state_nx = RUN;
        endcase
    end

    // FSM outputs
    always_comb begin
        stall_id   = hazard && !freeze && (state == RUN);
        in_ldstall = (state == LDSTALL) && !freeze;
    end

    assign issue    = id_valid && !stall_id;
    assign ex_valid = ex_s.valid;

    // Slot pipeline and registered operands; freeze holds everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_s       <= '0;
            mem_s      <= '0;
            wb_s       <= '0;
            ex_is_load <= 1'b0;
            ex_opa     <= '0;
            ex_opb     <= '0;
            fwd_sel_a  <= 2'b00;
            fwd_sel_b  <= 2'b00;
        end else if (!freeze) begin
            wb_s  <= mem_s;
            mem_s <= ex_s;
            if (issue) begin
                ex_s       <= '{valid: 1'b1, rd: id_rd, we: id_we};
                ex_is_load <= id_is_load;
                ex_opa     <= opa_d;
                ex_opb     <= opb_d;
                fwd_sel_a  <= sel_a_d;
                fwd_sel_b  <= sel_b_d;
            end else begin
                ex_s       <= '0;
                ex_is_load <= 1'b0;
                ex_opa     <= '0;
                ex_opb     <= '0;
                fwd_sel_a  <= 2'b00;
                fwd_sel_b  <= 2'b00;
            end
        end
    end

`ifdef FWD_STATS_EN
    logic fwd_evt;
    assign fwd_evt = issue && ((sel_a_d != 2'b00) || (sel_b_d != 2'b00));

    // Saturating stall and forward event counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_stall <= '0;
            stat_fwd   <= '0;
        end else if (!freeze) begin
            if (in_ldstall && (stat_stall != 32'hFFFF_FFFF))
                stat_stall <= stat_stall + 32'd1;
            if (fwd_evt && (stat_fwd != 32'hFFFF_FFFF))
                stat_fwd <= stat_fwd + 32'd1;
        end
    end
`else
    logic unused_ldstall;
    assign unused_ldstall = in_ldstall;
    assign stat_stall     = '0;
    assign stat_fwd       = '0;
`endif

endmodule
